// File: rtl/mux_reg_n_if.sv
// ---------------------------------------------------------------------------
// mux_reg_n_if
// Groups the request and result signals of mux_reg_n.
//   in_bus     : N*WIDTH flattened inputs, input k at [k*WIDTH +: WIDTH]
//   sel        : input index for a single-shot load
//   load       : capture in[sel] into out
//   scan_start : begin streaming inputs 0..N-1, one per cycle
//   out        : registered selected data
//   out_valid  : one-cycle pulse, out was updated this cycle
//   out_idx    : index of the input currently held in out
//   busy       : high from the first scan output through the last
//   scan_last  : pulse alongside out_valid for input N-1 of a scan
//   sel_err    : pulse when an out-of-range load was rejected
// Modports: master drives the requests, slave (the selector) drives results.
// ---------------------------------------------------------------------------
interface mux_reg_n_if #(
  parameter int WIDTH = 32,
  parameter int N     = 9,
  parameter int SELW  = 4
);
  logic [N*WIDTH-1:0] in_bus;
  logic [SELW-1:0]    sel;
  logic               load;
  logic               scan_start;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic [SELW-1:0]    out_idx;
  logic               busy;
  logic               scan_last;
  logic               sel_err;

  modport master (
    output in_bus, sel, load, scan_start,
    input  out, out_valid, out_idx, busy, scan_last, sel_err
  );

  modport slave (
    input  in_bus, sel, load, scan_start,
    output out, out_valid, out_idx, busy, scan_last, sel_err
  );
endinterface

// File: rtl/mux_reg_n.sv
// ---------------------------------------------------------------------------
// mux_reg_n
// N-input, WIDTH-bit selector with a registered output. Two modes:
//   - single-shot: load captures in[sel] into out one cycle later;
//   - scan: scan_start streams in[0..N-1] into out on N consecutive cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : mux_reg_n_if.slave (in_bus, sel, load, scan_start in;
//           out, out_valid, out_idx, busy, scan_last, sel_err out)
// Parameters: WIDTH (bits per input), N (inputs, 2..16), SELW (2**SELW >= N).
// Build option: define MUX_REG_SEL_CHECK_EN to reject loads with sel >= N
// (out held, sel_err pulsed). Without it such loads select in[N-1] and
// sel_err stays 0.
// ---------------------------------------------------------------------------
module mux_reg_n #(
  parameter int WIDTH = 32,
  parameter int N     = 9,
  parameter int SELW  = 4
) (
  input  logic         clk,
  input  logic         reset,
  mux_reg_n_if.slave   bus
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [SELW-1:0]   idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  logic [SELW-1:0]   load_idx;
  logic [SELW-1:0]   mux_idx;
  logic [WIDTH-1:0]  mux_data;

  // Out-of-range selects fold onto the last input; the checked build never
  // uses this value for a rejected load, so the clamp is harmless there.
  // The mux index is chosen here so the FSM block only consumes mux_data.
  always_comb begin
    load_idx = (bus.sel > LAST) ? LAST : bus.sel;
    if (state_q == SCAN)     mux_idx = cnt_q;
    else if (bus.scan_start) mux_idx = '0;
    else                     mux_idx = load_idx;
  end

  // Compare-and-select against constant indices keeps every part-select
  // static and in range for any legal N.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < N; k++) begin
      if (mux_idx == SELW'(k)) mux_data = bus.in_bus[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // busy_q still high here means the last scan output is on the bus;
        // that cycle is the mandatory bubble and all requests are ignored.
        if (!busy_q) begin
          if (bus.scan_start) begin
            state_d = SCAN;
            cnt_d   = SELW'(1);
            out_d   = mux_data;
            idx_d   = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else if (bus.load) begin
`ifdef MUX_REG_SEL_CHECK_EN
            if (bus.sel > LAST) begin
              err_d = 1'b1;
            end else begin
              out_d   = mux_data;
              idx_d   = load_idx;
              valid_d = 1'b1;
            end
`else
            out_d   = mux_data;
            idx_d   = load_idx;
            valid_d = 1'b1;
`endif
          end
        end
      end

      SCAN: begin
        out_d   = mux_data;
        idx_d   = cnt_q;
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (cnt_q == LAST) begin
          last_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.scan_last = last_q;
  assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_mux_reg_n.sv
// ---------------------------------------------------------------------------
// tb_mux_reg_n
// Directed bench for mux_reg_n: a 9x32 instance and a 3x8 instance share
// clk/reset. Expected values are written out by hand from the input
// patterns in[k] = 32'h1000_0000 + k and in[k] = 8'hA0 + k.
// Out-of-range expectations follow MUX_REG_SEL_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_mux_reg_n;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux_reg_n_if #(.WIDTH(32), .N(9), .SELW(4)) if0 ();
  mux_reg_n_if #(.WIDTH(8),  .N(3), .SELW(2)) if1 ();

  mux_reg_n #(.WIDTH(32), .N(9), .SELW(4)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  mux_reg_n #(.WIDTH(8), .N(3), .SELW(2)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then return on the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_inputs();
    for (int k = 0; k < 9; k++) if0.in_bus[k*32 +: 32] = 32'h1000_0000 + k;
    for (int k = 0; k < 3; k++) if1.in_bus[k*8 +: 8]   = 8'hA0 + 8'(k);
  endtask

  // Full 9-input scan on u0. with_load holds load=1, sel=3 from the start
  // edge through the bubble edge; it must never change the sequence.
  task automatic run_scan(input bit with_load);
    if0.scan_start = 1'b1;
    if (with_load) begin
      if0.load = 1'b1;
      if0.sel  = 4'd3;
    end
    step();
    if0.scan_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("scan out %0d", i),   if0.out, 32'h1000_0000 + i);
      check($sformatf("scan idx %0d", i),   32'(if0.out_idx), 32'(i));
      check($sformatf("scan valid %0d", i), 32'(if0.out_valid), 32'd1);
      check($sformatf("scan busy %0d", i),  32'(if0.busy), 32'd1);
      check($sformatf("scan last %0d", i),  32'(if0.scan_last), (i == 8) ? 32'd1 : 32'd0);
      check($sformatf("scan err %0d", i),   32'(if0.sel_err), 32'd0);
      if (i < 8) step();
    end
    step();
    check("bubble valid", 32'(if0.out_valid), 32'd0);
    check("bubble busy",  32'(if0.busy), 32'd0);
    check("bubble last",  32'(if0.scan_last), 32'd0);
    check("bubble out",   if0.out, 32'h1000_0008);
    check("bubble idx",   32'(if0.out_idx), 32'd8);
    if0.load = 1'b0;
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    if0.sel = '0; if0.load = 1'b0; if0.scan_start = 1'b0;
    if1.sel = '0; if1.load = 1'b0; if1.scan_start = 1'b0;
    fill_inputs();

    @(negedge clk);
    check("rst out",   if0.out, 32'd0);
    check("rst idx",   32'(if0.out_idx), 32'd0);
    check("rst valid", 32'(if0.out_valid), 32'd0);
    check("rst busy",  32'(if0.busy), 32'd0);
    check("rst last",  32'(if0.scan_last), 32'd0);
    check("rst err",   32'(if0.sel_err), 32'd0);
    reset = 1'b0;
    step();
    check("idle valid", 32'(if0.out_valid), 32'd0);

    // Single-shot load of in[5], then change the input and confirm the hold.
    if0.load = 1'b1; if0.sel = 4'd5;
    step();
    if0.load = 1'b0;
    check("load out",   if0.out, 32'h1000_0005);
    check("load idx",   32'(if0.out_idx), 32'd5);
    check("load valid", 32'(if0.out_valid), 32'd1);
    check("load busy",  32'(if0.busy), 32'd0);
    if0.in_bus[5*32 +: 32] = 32'hDEAD_BEEF;
    step();
    check("hold valid", 32'(if0.out_valid), 32'd0);
    check("hold out",   if0.out, 32'h1000_0005);
    check("hold idx",   32'(if0.out_idx), 32'd5);
    fill_inputs();

    // Plain scan, then scan with a competing load asserted throughout
    // (covers load while busy and load together with scan_start).
    run_scan(1'b0);
    run_scan(1'b1);

    // Out-of-range load after a known in-range load.
    if0.load = 1'b1; if0.sel = 4'd2;
    step();
    check("load2 out", if0.out, 32'h1000_0002);
    if0.sel = 4'd12;
    step();
    if0.load = 1'b0;
`ifdef MUX_REG_SEL_CHECK_EN
    check("oor out",   if0.out, 32'h1000_0002);
    check("oor idx",   32'(if0.out_idx), 32'd2);
    check("oor valid", 32'(if0.out_valid), 32'd0);
    check("oor err",   32'(if0.sel_err), 32'd1);
`else
    check("oor out",   if0.out, 32'h1000_0008);
    check("oor idx",   32'(if0.out_idx), 32'd8);
    check("oor valid", 32'(if0.out_valid), 32'd1);
    check("oor err",   32'(if0.sel_err), 32'd0);
`endif
    step();
    check("oor err clr", 32'(if0.sel_err), 32'd0);
    check("oor valid clr", 32'(if0.out_valid), 32'd0);

    // Reset in the middle of a scan, asserted between clock edges.
    if0.scan_start = 1'b1;
    step();
    if0.scan_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pre-rst idx %0d", i), 32'(if0.out_idx), 32'(i));
      if (i < 3) step();
    end
    #2 reset = 1'b1;
    #1;
    check("arst out",   if0.out, 32'd0);
    check("arst idx",   32'(if0.out_idx), 32'd0);
    check("arst valid", 32'(if0.out_valid), 32'd0);
    check("arst busy",  32'(if0.busy), 32'd0);
    check("arst last",  32'(if0.scan_last), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("arst hold last",  32'(if0.scan_last), 32'd0);
      check("arst hold valid", 32'(if0.out_valid), 32'd0);
    end
    reset = 1'b0;
    step();
    run_scan(1'b0);

    // Narrow instance: 3 inputs of 8 bits, 2-bit select.
    if1.scan_start = 1'b1;
    step();
    if1.scan_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("n3 out %0d", i),  32'(if1.out), 32'hA0 + i);
      check($sformatf("n3 idx %0d", i),  32'(if1.out_idx), 32'(i));
      check($sformatf("n3 busy %0d", i), 32'(if1.busy), 32'd1);
      check($sformatf("n3 last %0d", i), 32'(if1.scan_last), (i == 2) ? 32'd1 : 32'd0);
      if (i < 2) step();
    end
    step();
    check("n3 bubble busy",  32'(if1.busy), 32'd0);
    check("n3 bubble valid", 32'(if1.out_valid), 32'd0);
    if1.load = 1'b1; if1.sel = 2'd0;
    step();
    check("n3 load0 out", 32'(if1.out), 32'hA0);
    if1.sel = 2'd3;
    step();
    if1.load = 1'b0;
`ifdef MUX_REG_SEL_CHECK_EN
    check("n3 oor out",   32'(if1.out), 32'hA0);
    check("n3 oor idx",   32'(if1.out_idx), 32'd0);
    check("n3 oor valid", 32'(if1.out_valid), 32'd0);
    check("n3 oor err",   32'(if1.sel_err), 32'd1);
`else
    check("n3 oor out",   32'(if1.out), 32'hA2);
    check("n3 oor idx",   32'(if1.out_idx), 32'd2);
    check("n3 oor valid", 32'(if1.out_valid), 32'd1);
    check("n3 oor err",   32'(if1.sel_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
